// File: rtl/lcd_cmd_sched.sv
// Command scheduler between a host FIFO and LCD_CTRL: strictly ordered issue,
// a short busy guard after ordinary commands, and a watched write-back for WRITE.
module lcd_cmd_sched #(
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [3:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic [4:0] q_count,
    output logic [5:0] issued,
    output logic       fin,
    output logic       err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WAIT_DONE,
        S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [3:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [4:0]      r_count;
    logic [3:0]      r_cmd;
    logic            r_valid;
    logic [5:0]      r_issued;
    logic            r_fin;
    logic            r_err;
    logic [7:0]      r_tmo;
    logic            r_wait_cnt;

    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_tmo_hit;
    logic            w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_tmo_hit = (r_tmo == 8'(TMO - 1));
        case (r_state)
            S_IDLE:      if (r_count != '0 && !lcd_busy) w_next = S_ISSUE;
            S_ISSUE:     w_next = (r_cmd == 4'h0) ? S_WAIT_DONE : S_WAIT;
            S_WAIT:      if (r_wait_cnt && !lcd_busy) w_next = S_IDLE;
            // lcd_done takes priority over the timeout on the final cycle
            S_WAIT_DONE: if (lcd_done || w_tmo_hit) w_next = S_FIN;
            S_FIN:       w_next = S_FIN;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        host_ready = !reset && (r_count != 5'(DEPTH)) && (r_state != S_FIN);
        w_push     = host_valid && host_ready;
        w_pop      = (r_state == S_IDLE) && (w_next == S_ISSUE);
        w_flush    = (w_next == S_FIN);
        w_timeout  = (r_state == S_WAIT_DONE) && !lcd_done && w_tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_cmd      <= '0;
            r_valid    <= 1'b0;
            r_issued   <= '0;
            r_fin      <= 1'b0;
            r_err      <= 1'b0;
            r_tmo      <= '0;
            r_wait_cnt <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= host_cmd;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + 5'(w_push) - 5'(w_pop);
            end
            if (w_pop) begin
                r_cmd <= r_mem[r_rd_ptr];
            end
            r_valid <= w_pop;
            if (r_state == S_ISSUE) begin
                r_issued   <= r_issued + 1'b1;
                r_tmo      <= '0;
                r_wait_cnt <= 1'b0;
            end else begin
                if (r_state == S_WAIT_DONE) r_tmo <= r_tmo + 1'b1;
                if (r_state == S_WAIT) r_wait_cnt <= 1'b1;
            end
            if (w_flush) r_fin <= 1'b1;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign lcd_cmd       = r_cmd;
    assign lcd_cmd_valid = r_valid;
    assign q_count       = r_count;
    assign issued        = r_issued;
    assign fin           = r_fin;
    assign err           = r_err;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Bench for lcd_cmd_sched: cycle-level reference model built from queues and
// cycle numbers, plus an issue scoreboard drained by an independent monitor.
module tb_lcd_cmd_sched;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [3:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       lcd_busy;
    logic       lcd_done;
    logic [4:0] q_count;
    logic [5:0] issued;
    logic       fin;
    logic       err;

    lcd_cmd_sched #(.DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .host_cmd      (host_cmd),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .lcd_cmd       (lcd_cmd),
        .lcd_cmd_valid (lcd_cmd_valid),
        .lcd_busy      (lcd_busy),
        .lcd_done      (lcd_done),
        .q_count       (q_count),
        .issued        (issued),
        .fin           (fin),
        .err           (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [3:0] cmd;
        int         at;
    } issue_t;
    issue_t sb[$];

    // Reference model: values expected during the current cycle
    int unsigned m_q[$];
    logic [3:0]  m_cmd;
    bit          m_valid;
    int          m_issued;
    bit          m_fin;
    bit          m_err;
    bit          m_free;
    bit          m_wr_pend;
    int          m_wr_age;
    bit          m_rel_pend;
    int          m_rel_from;
    bit          mon_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic bit m_ready(input bit rst);
        return !rst && (m_q.size() < DEPTH) && !m_fin;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_cmd      = 4'h0;
        m_valid    = 1'b0;
        m_issued   = 0;
        m_fin      = 1'b0;
        m_err      = 1'b0;
        m_free     = 1'b1;
        m_wr_pend  = 1'b0;
        m_wr_age   = 0;
        m_rel_pend = 1'b0;
        m_rel_from = 0;
    endfunction

    function automatic void model_advance(input bit rst, input bit v, input logic [3:0] cmd,
                                          input bit busy, input bit done);
        bit push;
        bit flush;
        bit n_valid;
        if (rst) begin
            model_reset();
            return;
        end
        push    = v && m_ready(rst);
        flush   = 1'b0;
        n_valid = 1'b0;
        if (m_fin) begin
            flush = 1'b1;
        end else if (m_valid) begin
            m_issued = (m_issued + 1) % 64;
            if (m_cmd == 4'h0) begin
                m_wr_pend = 1'b1;
                m_wr_age  = 0;
            end else begin
                m_rel_pend = 1'b1;
                m_rel_from = cyc + 2;
            end
        end else if (m_wr_pend) begin
            if (done || m_wr_age == TMO - 1) begin
                m_wr_pend = 1'b0;
                m_fin     = 1'b1;
                m_err     = m_err || !done;
                flush     = 1'b1;
            end else begin
                m_wr_age++;
            end
        end else if (m_rel_pend) begin
            if (cyc >= m_rel_from && !busy) begin
                m_rel_pend = 1'b0;
                m_free     = 1'b1;
            end
        end else if (m_free && m_q.size() != 0 && !busy) begin
            m_cmd   = 4'(m_q.pop_front());
            n_valid = 1'b1;
            m_free  = 1'b0;
            sb.push_back('{cmd: m_cmd, at: cyc + 1});
        end
        if (push) m_q.push_back(int'(cmd));
        if (flush) m_q.delete();
        m_valid = n_valid;
    endfunction

    task automatic step(input bit rst, input bit v, input logic [3:0] cmd,
                        input bit busy, input bit done);
        @(negedge clk);
        reset      = rst;
        host_valid = v;
        host_cmd   = cmd;
        lcd_busy   = busy;
        lcd_done   = done;
        #1;
        chk("q_count",    32'(q_count),       32'(m_q.size()));
        chk("host_ready", 32'(host_ready),    32'(m_ready(rst)));
        chk("lcd_cmd",    32'(lcd_cmd),       32'(m_cmd));
        chk("cmd_valid",  32'(lcd_cmd_valid), 32'(m_valid));
        chk("issued",     32'(issued),        32'(m_issued));
        chk("fin",        32'(fin),           32'(m_fin));
        chk("err",        32'(err),           32'(m_err));
        model_advance(rst, v, cmd, busy, done);
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, busy, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en && lcd_cmd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", 32'(lcd_cmd), 32'hFFFF_FFFF);
            end else begin
                issue_t e;
                e = sb.pop_front();
                chk("issue_cmd",   32'(lcd_cmd), 32'(e.cmd));
                chk("issue_cycle", 32'(cyc),     32'(e.at));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = 4'h0;
        lcd_busy   = 1'b0;
        lcd_done   = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        mon_en = 1'b1;
        do_reset(1);

        // In-order issue of three ordinary commands, 4 cycles apart
        step(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        idle(20, 1'b0);
        chk("seq_issued", 32'(issued), 32'd3);

        // FIFO fills while LCD_CTRL is busy; fifth push refused
        do_reset(2);
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 4'(i), 1'b1, 1'b0);
        chk("full_count", 32'(q_count), 32'd4);
        idle(5, 1'b1);
        idle(30, 1'b0);

        // WRITE completed 10 cycles after its issue; later pushes ignored
        do_reset(2);
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++)
            step(1'b0, 1'b0, 4'h0, 1'b0, m_wr_pend && m_wr_age == 9);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'(i + 3), 1'b0, 1'b0);

        // WRITE never completed: timeout
        do_reset(2);
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        idle(TMO + 8, 1'b0);

        // lcd_done on the final timeout cycle counts as success
        do_reset(2);
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < TMO + 8; i++)
            step(1'b0, 1'b0, 4'h0, 1'b0, m_wr_pend && m_wr_age == TMO - 1);

        // Commands queued behind a WRITE are flushed
        do_reset(2);
        step(1'b0, 1'b1, 4'h5, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'h6, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++)
            step(1'b0, 1'b0, 4'h0, 1'b0, m_wr_pend && m_wr_age == 3);
        chk("flush_issued", 32'(issued), 32'd2);

        // Reset during the ISSUE cycle of 4'h7 with two entries behind it
        do_reset(2);
        step(1'b0, 1'b1, 4'h7, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'h1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'h2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
        idle(6, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit          r;
            bit          v;
            logic [3:0]  c;
            bit          b;
            bit          d;
            r = ($urandom_range(0, 299) == 0) || (m_fin && $urandom_range(0, 7) == 0);
            v = $urandom_range(0, 1) == 1;
            c = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            b = $urandom_range(0, 9) < 3;
            d = $urandom_range(0, 19) == 0;
            step(r, v, c, b, d);
        end

        do_reset(3);
        @(negedge clk);
        while (sb.size() != 0) begin
            issue_t e;
            e = sb.pop_front();
            chk("missing_issue", 32'hFFFF_FFFF, 32'(e.cmd));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_sched.md
LCD_CMD_SCHED -- requirements
Module: lcd_cmd_sched

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 Parameter TMO, default 255, max cycles waiting for lcd_done after WRITE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 host_cmd  input  4  command code from host.
REQ-006 host_valid  input  1  host_cmd valid this cycle.
REQ-007 host_ready  output  1  scheduler accepts host_cmd this cycle.
REQ-008 lcd_cmd  output  4  command driven to LCD_CTRL.
REQ-009 lcd_cmd_valid  output  1  one-cycle command strobe to LCD_CTRL.
REQ-010 lcd_busy  input  1  LCD_CTRL busy.
REQ-011 lcd_done  input  1  LCD_CTRL image write-back complete.
REQ-012 q_count  output  5  current FIFO occupancy, 0..DEPTH.
REQ-013 issued  output  6  commands issued since reset, wraps 63->0.
REQ-014 fin  output  1  sequence finished; sticky until reset.
REQ-015 err  output  1  lcd_done timeout; sticky until reset.

Function
REQ-016 Push when host_valid && host_ready at a rising edge; host_ready = !(q_count==DEPTH) && state!=FIN, derived from registered state only.
REQ-017 FIFO order strictly first-in first-out; no bypass: an entry pushed into an empty FIFO is poppable no earlier than the following cycle.
REQ-018 Simultaneous push and pop in one cycle: both take effect, q_count unchanged; push while full is impossible because host_ready=0.
REQ-019 States: IDLE, ISSUE, WAIT, WAIT_DONE, FIN; state register, lcd_cmd and lcd_cmd_valid are registered.
REQ-020 IDLE: if q_count!=0 and lcd_busy==0, pop head into lcd_cmd and go to ISSUE; else stay.
REQ-021 ISSUE: lcd_cmd_valid=1 for exactly this one cycle; issued increments by 1; next state WAIT_DONE if lcd_cmd==4'h0 (WRITE), else WAIT.
REQ-022 lcd_cmd_valid is 0 in every state other than ISSUE.
REQ-023 WAIT: hold a minimum of 2 cycles (guard for LCD_CTRL busy latency), then return to IDLE on the first cycle lcd_busy==0.
REQ-024 WAIT_DONE: 8-bit timeout counter cleared on entry and incremented each cycle; lcd_done==1 -> FIN with err unchanged; counter reaching TMO without lcd_done -> FIN with err=1.
REQ-025 lcd_done==1 on the same cycle the counter reaches TMO: treated as success, err stays 0.
REQ-026 lcd_done outside WAIT_DONE is ignored.
REQ-027 FIN: fin=1, FIFO flushed (q_count=0 the cycle after entry), host_ready=0, no further issue; exit only by reset.
REQ-028 Back-to-back issues: minimum spacing is 4 cycles between lcd_cmd_valid pulses (ISSUE, 2 WAIT cycles, IDLE).
REQ-029 lcd_cmd holds its last issued value in all states until the next pop.

Reset
REQ-030 reset sampled high: next state IDLE, FIFO empty, q_count=0, issued=0, lcd_cmd=4'h0, lcd_cmd_valid=0, fin=0, err=0, timeout counter=0.
REQ-031 host_ready=0 during every cycle reset is high; a push presented in a cycle with reset high is discarded.
REQ-032 Reset asserted mid-operation in any state, including ISSUE or WAIT_DONE, aborts it with no further lcd_cmd_valid pulse; outputs take REQ-030 values from the next edge.

Verification
REQ-033 Push 4'h1,4'h2,4'h3 with lcd_busy=0 -> lcd_cmd_valid pulses carry 1,2,3 in order, 4 cycles apart; issued=3; q_count returns to 0.
REQ-034 lcd_busy held 1 while pushing DEPTH=4 commands -> host_ready=0 with q_count=4; 5th push not accepted; no lcd_cmd_valid until lcd_busy falls.
REQ-035 Push 4'h0 (WRITE); lcd_done pulses 10 cycles after the ISSUE cycle -> fin=1, err=0, host_ready=0; later pushes ignored.
REQ-036 Push 4'h0; lcd_done never asserted -> fin=1 and err=1 TMO cycles after entry to WAIT_DONE.
REQ-037 Push 4'h5,4'h0,4'h6; complete WRITE -> 4'h6 never issued, q_count=0 after FIN entry, issued=2.
REQ-038 Assert reset in the ISSUE cycle of command 4'h7 with 2 entries queued -> next cycle lcd_cmd_valid=0, q_count=0, issued=0, fin=0, err=0.
